// File: rtl/simd_register_file_pkg.sv
// Shared core encodings: FSM states, writeback source select, special register indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simd_register_file_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        MUX_ARITHMETIC = 2'b00,
        MUX_MEMORY     = 2'b01,
        MUX_CONSTANT   = 2'b10,
        MUX_RESERVED   = 2'b11
    } reg_input_mux_t;

    localparam logic [3:0] BLOCK_IDX  = 4'd13;
    localparam logic [3:0] BLOCK_DIM  = 4'd14;
    localparam logic [3:0] THREAD_IDX = 4'd15;

endpackage

// File: rtl/simd_register_file_vreg_lane_merge.sv
// Replaces one byte lane of a vector with a new byte, other lanes pass through.
// Latency: combinational.
// Backpressure: none.
module vreg_lane_merge #(
    parameter int VECTOR_SIZE = 4,
    parameter int LANE_W      = $clog2(VECTOR_SIZE)
) (
    input  logic [8*VECTOR_SIZE-1:0] old_vec,
    input  logic [LANE_W-1:0]        lane_idx,
    input  logic [7:0]               lane_dat,
    output logic [8*VECTOR_SIZE-1:0] merged_vec
);

    always_comb begin
        merged_vec = old_vec;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (lane_idx == LANE_W'(i)) begin
                merged_vec[8*i +: 8] = lane_dat;
            end
        end
    end

endmodule

// File: rtl/simd_register_file.sv
// Per-thread scalar + vector register file; operands latched in REQUEST, writeback in UPDATE.
// Latency: 1 cycle REQUEST->operands; writes visible to the next REQUEST.
// Backpressure: none; enable=0 freezes all state and outputs.
module simd_register_file
    import simd_register_file_pkg::*;
#(
    parameter int Vector_Size       = 4,
    parameter int VREG_COUNT        = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               block_id,
    input  logic [2:0]               core_state,
    input  logic [3:0]               decoded_rd_address,
    input  logic [3:0]               decoded_rs_address,
    input  logic [3:0]               decoded_rt_address,
    input  logic                     decoded_reg_write_enable,
    input  logic                     decoded_vector_write_enable,
    input  logic [1:0]               decoded_reg_input_mux,
    input  logic [7:0]               decoded_immediate,
    input  logic [7:0]               alu_out,
    input  logic [8*Vector_Size-1:0] v_alu_out,
    input  logic [7:0]               lsu_out,
    output logic [7:0]               rs,
    output logic [7:0]               rt,
    output logic [8*Vector_Size-1:0] v_rs,
    output logic [8*Vector_Size-1:0] v_rt
);

    localparam int VW     = 8 * Vector_Size;
    localparam int LANE_W = $clog2(Vector_Size);
    localparam int VA_W   = (VREG_COUNT > 1) ? $clog2(VREG_COUNT) : 1;

    logic [7:0]    sreg [16];
    logic [VW-1:0] vreg [VREG_COUNT];

    logic [VA_W-1:0] vd_idx, vs_idx, vt_idx;
    logic [VW-1:0]   lane_merged;

    // Vector bank is addressed by the low bits of the 4-bit register address.
    assign vd_idx = (VREG_COUNT > 1) ? decoded_rd_address[VA_W-1:0] : '0;
    assign vs_idx = (VREG_COUNT > 1) ? decoded_rs_address[VA_W-1:0] : '0;
    assign vt_idx = (VREG_COUNT > 1) ? decoded_rt_address[VA_W-1:0] : '0;

    vreg_lane_merge #(
        .VECTOR_SIZE(Vector_Size),
        .LANE_W     (LANE_W)
    ) u_lane_merge (
        .old_vec   (vreg[vd_idx]),
        .lane_idx  (decoded_immediate[LANE_W-1:0]),
        .lane_dat  (lsu_out),
        .merged_vec(lane_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                sreg[i] <= 8'h00;
            end
            sreg[BLOCK_DIM]  <= 8'(THREADS_PER_BLOCK);
            sreg[THREAD_IDX] <= 8'(THREAD_ID);
            for (int i = 0; i < VREG_COUNT; i++) begin
                vreg[i] <= '0;
            end
            rs   <= 8'h00;
            rt   <= 8'h00;
            v_rs <= '0;
            v_rt <= '0;
        end else if (enable) begin
            sreg[BLOCK_IDX] <= block_id;
            if (core_state == CORE_REQUEST) begin
                rs   <= sreg[decoded_rs_address];
                rt   <= sreg[decoded_rt_address];
                v_rs <= vreg[vs_idx];
                v_rt <= vreg[vt_idx];
            end else if (core_state == CORE_UPDATE) begin
                // R13..R15 are read-only to software; R13 tracks block_id above.
                if (decoded_reg_write_enable && (decoded_rd_address < BLOCK_IDX)) begin
                    case (decoded_reg_input_mux)
                        MUX_ARITHMETIC: sreg[decoded_rd_address] <= alu_out;
                        MUX_MEMORY:     sreg[decoded_rd_address] <= lsu_out;
                        MUX_CONSTANT:   sreg[decoded_rd_address] <= decoded_immediate;
                        default:        ;
                    endcase
                end
                if (decoded_vector_write_enable) begin
                    case (decoded_reg_input_mux)
                        MUX_ARITHMETIC: vreg[vd_idx] <= v_alu_out;
                        MUX_MEMORY:     vreg[vd_idx] <= lane_merged;
                        MUX_CONSTANT:   vreg[vd_idx] <= {Vector_Size{decoded_immediate}};
                        default:        ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_register_file.sv
// Randomized + directed bench for simd_register_file with a queue-based scoreboard.
module tb_simd_register_file;

    localparam int VS  = 4;
    localparam int VC  = 4;
    localparam int TPB = 4;
    localparam int TID = 5;
    localparam int VW  = 8 * VS;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_REQ  = 3'b011;
    localparam logic [2:0] ST_WAIT = 3'b100;
    localparam logic [2:0] ST_UPD  = 3'b110;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [7:0]    block_id;
    logic [2:0]    core_state;
    logic [3:0]    rd_a, rs_a, rt_a;
    logic          we, vwe;
    logic [1:0]    mux;
    logic [7:0]    imm;
    logic [7:0]    alu;
    logic [VW-1:0] valu;
    logic [7:0]    lsu;
    logic [7:0]    rs, rt;
    logic [VW-1:0] v_rs, v_rt;

    simd_register_file #(
        .Vector_Size      (VS),
        .VREG_COUNT       (VC),
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID        (TID)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .enable                     (enable),
        .block_id                   (block_id),
        .core_state                 (core_state),
        .decoded_rd_address         (rd_a),
        .decoded_rs_address         (rs_a),
        .decoded_rt_address         (rt_a),
        .decoded_reg_write_enable   (we),
        .decoded_vector_write_enable(vwe),
        .decoded_reg_input_mux      (mux),
        .decoded_immediate          (imm),
        .alu_out                    (alu),
        .v_alu_out                  (valu),
        .lsu_out                    (lsu),
        .rs                         (rs),
        .rt                         (rt),
        .v_rs                       (v_rs),
        .v_rt                       (v_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    rs;
        logic [7:0]    rt;
        logic [VW-1:0] vrs;
        logic [VW-1:0] vrt;
    } exp_t;

    logic [7:0] m_s [16];
    logic [7:0] m_v [VC][VS];
    exp_t       exp_q [$];
    exp_t       last_exp;
    logic       mon_req, mon_rst;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [VW-1:0] vpack(input int idx);
        logic [VW-1:0] r;
        for (int l = 0; l < VS; l++) r[8*l +: 8] = m_v[idx][l];
        return r;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_s[i] = 8'h00;
        m_s[14] = 8'(TPB);
        m_s[15] = 8'(TID);
        for (int v = 0; v < VC; v++)
            for (int l = 0; l < VS; l++) m_v[v][l] = 8'h00;
    endtask

    // Reference writeback, computed from the register-file rules directly.
    task automatic model_update();
        int vd;
        vd = int'(rd_a) % VC;
        if (we && rd_a < 13) begin
            if (mux == 2'd0) m_s[rd_a] = alu;
            else if (mux == 2'd1) m_s[rd_a] = lsu;
            else if (mux == 2'd2) m_s[rd_a] = imm;
        end
        if (vwe) begin
            if (mux == 2'd0) begin
                for (int l = 0; l < VS; l++) m_v[vd][l] = valu[8*l +: 8];
            end else if (mux == 2'd1) begin
                m_v[vd][int'(imm) % VS] = lsu;
            end else if (mux == 2'd2) begin
                for (int l = 0; l < VS; l++) m_v[vd][l] = imm;
            end
        end
    endtask

    // Called at a negedge with the data fields already set; returns at the next negedge.
    task automatic step(input logic [2:0] st, input logic en);
        exp_t e;
        core_state = st;
        enable     = en;
        if (en && st == ST_REQ) begin
            e.rs  = m_s[rs_a];
            e.rt  = m_s[rt_a];
            e.vrs = vpack(int'(rs_a) % VC);
            e.vrt = vpack(int'(rt_a) % VC);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (en && !reset) begin
            m_s[13] = block_id;
            if (st == ST_UPD) model_update();
        end
        @(negedge clk);
    endtask

    task automatic clear_fields();
        we = 0; vwe = 0; mux = 0; imm = 0; alu = 0; valu = '0; lsu = 0;
        rd_a = 0; rs_a = 0; rt_a = 0;
    endtask

    task automatic req(input logic [3:0] a, input logic [3:0] b);
        clear_fields();
        rs_a = a;
        rt_a = b;
        step(ST_REQ, 1'b1);
        core_state = ST_WAIT;
    endtask

    // Monitor: outputs must always equal the most recent expected operand set.
    always @(posedge clk) begin
        mon_req = (core_state == ST_REQ) && enable && !reset;
        mon_rst = reset;
        #1;
        if (mon_rst) begin
            last_exp = '0;
        end else if (mon_req) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got request with empty queue at %0t", $time);
            end else begin
                last_exp = exp_q.pop_front();
            end
        end
        check("mon_rs", VW'(rs), VW'(last_exp.rs));
        check("mon_rt", VW'(rt), VW'(last_exp.rt));
        check("mon_v_rs", v_rs, last_exp.vrs);
        check("mon_v_rt", v_rt, last_exp.vrt);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; enable = 0; block_id = 0; core_state = ST_IDLE;
        clear_fields();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        check("reset_rs", VW'(rs), '0);
        check("reset_v_rt", v_rt, '0);

        // Scalar constant write then read back with threadIdx.
        clear_fields(); we = 1; rd_a = 3; mux = 2'b10; imm = 8'h5A;
        step(ST_UPD, 1);
        core_state = ST_WAIT; step(ST_WAIT, 1);
        req(4'd3, 4'd15);
        check("scalar_rs", VW'(rs), VW'(8'h5A));
        check("scalar_rt_tid", VW'(rt), VW'(TID));

        // Special registers are not software-writable.
        block_id = 8'h07;
        clear_fields(); we = 1; rd_a = 13; mux = 2'b00; alu = 8'hFF;
        step(ST_UPD, 1);
        clear_fields(); we = 1; rd_a = 14; mux = 2'b10; imm = 8'h33;
        step(ST_UPD, 1);
        step(ST_WAIT, 1);
        req(4'd13, 4'd14);
        check("r13_block_id", VW'(rs), VW'(8'h07));
        check("r14_read_only", VW'(rt), VW'(8'h04));

        // Full vector write then single-lane load merge.
        clear_fields(); vwe = 1; rd_a = 2; mux = 2'b00; valu = 32'h04030201;
        step(ST_UPD, 1);
        clear_fields(); vwe = 1; rd_a = 2; mux = 2'b01; imm = 8'd2; lsu = 8'hAA;
        step(ST_UPD, 1);
        step(ST_WAIT, 1);
        req(4'd2, 4'd6);
        check("vec_lane_merge", v_rs, 32'h04AA0201);
        check("vec_alias_low_bits", v_rt, 32'h04AA0201);

        // Broadcast with both banks written on the same edge.
        clear_fields(); we = 1; vwe = 1; rd_a = 1; mux = 2'b10; imm = 8'h11;
        step(ST_UPD, 1);
        step(ST_WAIT, 1);
        req(4'd1, 4'd1);
        check("dual_scalar", VW'(rs), VW'(8'h11));
        check("dual_vector", v_rs, 32'h11111111);

        // Freeze: nothing moves while enable is low.
        req(4'd3, 4'd2);
        block_id = 8'h99;
        clear_fields(); rs_a = 1; rt_a = 13;
        step(ST_REQ, 0);
        clear_fields(); we = 1; vwe = 1; rd_a = 3; mux = 2'b00; alu = 8'hC3; valu = 32'hDEADBEEF;
        step(ST_UPD, 0);
        check("freeze_rs", VW'(rs), VW'(8'h5A));
        check("freeze_v_rt", v_rt, 32'h04AA0201);
        block_id = 8'h07;
        req(4'd3, 4'd13);
        check("freeze_r3_kept", VW'(rs), VW'(8'h5A));
        check("freeze_r13_kept", VW'(rt), VW'(8'h07));
        req(4'd3, 4'd3);
        check("freeze_v3_kept", v_rs, 32'h00000000);

        // Random traffic against the reference model.
        for (int it = 0; it < 600; it++) begin
            logic [2:0] st;
            int sel;
            sel = $urandom_range(0, 9);
            st = (sel < 4) ? ST_REQ : (sel < 8) ? ST_UPD : 3'($urandom_range(0, 7));
            block_id = 8'($urandom);
            rd_a = 4'($urandom); rs_a = 4'($urandom); rt_a = 4'($urandom);
            we = 1'($urandom); vwe = 1'($urandom); mux = 2'($urandom);
            imm = 8'($urandom); alu = 8'($urandom); lsu = 8'($urandom);
            valu = VW'($urandom);
            step(st, ($urandom_range(0, 7) != 0));
        end

        // Async reset in the middle of an UPDATE with a write pending.
        req(4'd3, 4'd1);
        clear_fields(); we = 1; vwe = 1; rd_a = 0; mux = 2'b10; imm = 8'hEE;
        core_state = ST_UPD; enable = 1;
        #2 reset = 1;
        #1;
        check("async_rst_rs", VW'(rs), '0);
        check("async_rst_v_rs", v_rs, '0);
        @(posedge clk);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        core_state = ST_IDLE;
        reset = 0;
        step(ST_IDLE, 1);
        req(4'd0, 4'd14);
        check("post_rst_r0", VW'(rs), '0);
        check("post_rst_r14", VW'(rt), VW'(8'h04));
        req(4'd12, 4'd15);
        check("post_rst_r12", VW'(rs), '0);
        check("post_rst_r15", VW'(rt), VW'(TID));
        check("post_rst_v0", v_rs, '0);

        step(ST_IDLE, 1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
